// File: rtl/instr_exec_unit_if.sv
// Result channel between the execution stage and the scoreboard/result sink.
interface instr_exec_unit_if #(
  parameter int PTR_W = 5,
  parameter int RES_W = 64
);
  logic             res_valid;
  logic             res_ready;
  logic [PTR_W-1:0] res_ptr;
  logic [3:0]       res_opc;
  logic [RES_W-1:0] result;
  logic             div_zero;

  modport master (output res_valid, res_ptr, res_opc, result, div_zero, input res_ready);
  modport slave  (input res_valid, res_ptr, res_opc, result, div_zero, output res_ready);
endinterface

// File: rtl/instr_exec_unit.sv
// Execution stage: walks the instruction register from first_ptr to last_ptr and
// emits one signed result per instruction; DIV/MOD use a restoring divider.
module instr_exec_unit #(
  parameter int OP_W  = 32,
  parameter int PTR_W = 5,
  parameter int RES_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PTR_W-1:0] first_ptr,
  input  logic [PTR_W-1:0] last_ptr,
  output logic [PTR_W-1:0] read_pointer,
  input  logic [3:0]       instr_opc,
  input  logic [OP_W-1:0]  instr_op_a,
  input  logic [OP_W-1:0]  instr_op_b,
  output logic             busy,
  output logic             done,
  instr_exec_unit_if.master res
);

  localparam int CNT_W = $clog2(OP_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OP_W - 1);
  localparam logic [3:0] OPC_ZERO = 4'd0, OPC_PASSA = 4'd1, OPC_PASSB = 4'd2, OPC_ADD = 4'd3,
                         OPC_SUB = 4'd4, OPC_MULT = 4'd5, OPC_DIV = 4'd6, OPC_MOD = 4'd7;

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, DIVIDE, OUTPUT, DONE} state_t;

  state_t           state_r, next_s;
  logic [PTR_W-1:0] read_pointer_r, ptr_r, last_r, res_ptr_r;
  logic [3:0]       opc_r, res_opc_r;
  logic [OP_W-1:0]  a_r, b_r, rem_r, quo_r, dvs_r;
  logic [CNT_W-1:0] cnt_r;
  logic [RES_W-1:0] result_r;
  logic             res_valid_r, div_zero_r, busy_r, done_r;

  logic [RES_W-1:0] a_ext_s, b_ext_s, alu_s, q_ext_s, r_ext_s, div_res_s, mod_res_s;
  logic [OP_W-1:0]  a_mag_s, b_mag_s, rem_nx_s, quo_nx_s;
  logic [OP_W:0]    rem_sh_s, diff_s;
  logic             is_div_s, b_zero_s, handshake_s;
  logic             busy_nx_s, done_nx_s, valid_nx_s;

  assign a_ext_s     = {{(RES_W-OP_W){a_r[OP_W-1]}}, a_r};
  assign b_ext_s     = {{(RES_W-OP_W){b_r[OP_W-1]}}, b_r};
  assign a_mag_s     = a_r[OP_W-1] ? ({OP_W{1'b0}} - a_r) : a_r;
  assign b_mag_s     = b_r[OP_W-1] ? ({OP_W{1'b0}} - b_r) : b_r;
  assign is_div_s    = (opc_r == OPC_DIV) || (opc_r == OPC_MOD);
  assign b_zero_s    = (b_r == {OP_W{1'b0}});
  assign handshake_s = res_valid_r && res.res_ready;

  // Non-divide results; DIV/MOD and opcodes 8-15 yield zero here.
  always_comb begin
    alu_s = {RES_W{1'b0}};
    case (opc_r)
      OPC_ZERO:  alu_s = {RES_W{1'b0}};
      OPC_PASSA: alu_s = a_ext_s;
      OPC_PASSB: alu_s = b_ext_s;
      OPC_ADD:   alu_s = a_ext_s + b_ext_s;
      OPC_SUB:   alu_s = a_ext_s - b_ext_s;
      OPC_MULT:  alu_s = $signed(a_ext_s) * $signed(b_ext_s);
      default:   alu_s = {RES_W{1'b0}};
    endcase
  end

  // One restoring-division step on magnitudes, plus sign fix-up of the final values.
  always_comb begin
    rem_sh_s = {rem_r, quo_r[OP_W-1]};
    diff_s   = rem_sh_s - {1'b0, dvs_r};
    if (!diff_s[OP_W]) begin
      rem_nx_s = diff_s[OP_W-1:0];
      quo_nx_s = {quo_r[OP_W-2:0], 1'b1};
    end else begin
      rem_nx_s = rem_sh_s[OP_W-1:0];
      quo_nx_s = {quo_r[OP_W-2:0], 1'b0};
    end
    q_ext_s   = {{(RES_W-OP_W){1'b0}}, quo_nx_s};
    r_ext_s   = {{(RES_W-OP_W){1'b0}}, rem_nx_s};
    div_res_s = (a_r[OP_W-1] ^ b_r[OP_W-1]) ? ({RES_W{1'b0}} - q_ext_s) : q_ext_s;
    mod_res_s = a_r[OP_W-1] ? ({RES_W{1'b0}} - r_ext_s) : r_ext_s;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE:    next_s = start ? FETCH : IDLE;
      FETCH:   next_s = EXEC;
      EXEC:    next_s = (is_div_s && !b_zero_s) ? DIVIDE : OUTPUT;
      DIVIDE:  next_s = (cnt_r == CNT_LAST) ? OUTPUT : DIVIDE;
      OUTPUT: begin
        if (handshake_s) begin
          next_s = (res_ptr_r == last_r) ? DONE : FETCH;
        end else begin
          next_s = OUTPUT;
        end
      end
      DONE:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // Status outputs are decoded from the next state and registered below.
  always_comb begin
    busy_nx_s  = (next_s != IDLE);
    done_nx_s  = (next_s == DONE);
    valid_nx_s = (next_s == OUTPUT);
  end

  // Datapath, working registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_pointer_r <= {PTR_W{1'b0}};
      ptr_r          <= {PTR_W{1'b0}};
      last_r         <= {PTR_W{1'b0}};
      res_ptr_r      <= {PTR_W{1'b0}};
      opc_r          <= 4'd0;
      res_opc_r      <= 4'd0;
      a_r            <= {OP_W{1'b0}};
      b_r            <= {OP_W{1'b0}};
      rem_r          <= {OP_W{1'b0}};
      quo_r          <= {OP_W{1'b0}};
      dvs_r          <= {OP_W{1'b0}};
      cnt_r          <= {CNT_W{1'b0}};
      result_r       <= {RES_W{1'b0}};
      res_valid_r    <= 1'b0;
      div_zero_r     <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      busy_r      <= busy_nx_s;
      done_r      <= done_nx_s;
      res_valid_r <= valid_nx_s;
      case (state_r)
        IDLE: begin
          if (start) begin
            last_r         <= last_ptr;
            read_pointer_r <= first_ptr;
          end
        end
        FETCH: begin
          opc_r <= instr_opc;
          a_r   <= instr_op_a;
          b_r   <= instr_op_b;
          ptr_r <= read_pointer_r;
        end
        EXEC: begin
          if (is_div_s && !b_zero_s) begin
            rem_r <= {OP_W{1'b0}};
            quo_r <= a_mag_s;
            dvs_r <= b_mag_s;
            cnt_r <= {CNT_W{1'b0}};
          end else begin
            res_ptr_r  <= ptr_r;
            res_opc_r  <= opc_r;
            result_r   <= alu_s;
            div_zero_r <= is_div_s;
          end
        end
        DIVIDE: begin
          rem_r <= rem_nx_s;
          quo_r <= quo_nx_s;
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_LAST) begin
            res_ptr_r  <= ptr_r;
            res_opc_r  <= opc_r;
            result_r   <= (opc_r == OPC_MOD) ? mod_res_s : div_res_s;
            div_zero_r <= 1'b0;
          end
        end
        OUTPUT: begin
          if (handshake_s && (res_ptr_r != last_r)) begin
            read_pointer_r <= res_ptr_r + PTR_W'(1);
            div_zero_r     <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign read_pointer  = read_pointer_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign res.res_valid = res_valid_r;
  assign res.res_ptr   = res_ptr_r;
  assign res.res_opc   = res_opc_r;
  assign res.result    = result_r;
  assign res.div_zero  = div_zero_r;

endmodule

// File: tb/tb_instr_exec_unit.sv
// Directed bench for instr_exec_unit with a behavioural instruction register.
module tb_instr_exec_unit;
  localparam int OP_W = 32, PTR_W = 5, RES_W = 64;

  logic             clk = 1'b0;
  logic             reset, start;
  logic [PTR_W-1:0] first_ptr, last_ptr, read_pointer;
  logic [3:0]       instr_opc;
  logic [OP_W-1:0]  instr_op_a, instr_op_b;
  logic             busy, done;

  logic [3:0]       mem_opc [32];
  logic [OP_W-1:0]  mem_a [32];
  logic [OP_W-1:0]  mem_b [32];

  int vectors = 0;
  int miscompares = 0;

  instr_exec_unit_if #(.PTR_W(PTR_W), .RES_W(RES_W)) rif ();

  instr_exec_unit #(.OP_W(OP_W), .PTR_W(PTR_W), .RES_W(RES_W)) dut (
    .clk(clk), .reset(reset), .start(start), .first_ptr(first_ptr), .last_ptr(last_ptr),
    .read_pointer(read_pointer), .instr_opc(instr_opc), .instr_op_a(instr_op_a),
    .instr_op_b(instr_op_b), .busy(busy), .done(done), .res(rif)
  );

  always #5 clk = ~clk;

  assign instr_opc  = mem_opc[read_pointer];
  assign instr_op_a = mem_a[read_pointer];
  assign instr_op_b = mem_b[read_pointer];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_entry(input int idx, input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b);
    mem_opc[idx] = opc;
    mem_a[idx]   = a;
    mem_b[idx]   = b;
  endtask

  task automatic start_seq(input logic [4:0] f, input logic [4:0] l);
    first_ptr = f;
    last_ptr  = l;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  // Counts edges until res_valid; a timeout shows up as a latency miscompare.
  task automatic wait_valid(input string tag, input int exp_cyc);
    int cyc = 0;
    while (rif.res_valid !== 1'b1 && cyc < 200) begin
      step();
      cyc++;
    end
    chk(tag, 64'(cyc), 64'(exp_cyc));
  endtask

  longint exp3 [8] = '{0, -15, 4, -11, -19, -60, -3, -3};
  longint exp4 [6] = '{0, 0, 3, 64'h0000_0000_8000_0000, 64'h3FFF_FFFF_0000_0001, 1};
  int     dz4  [6] = '{1, 1, 0, 0, 0, 0};
  int     lat4 [6] = '{2, 2, 2, 34, 2, 34};
  int     ep5  [4] = '{30, 31, 0, 1};
  longint er5  [4] = '{99, -3, -21, -42};

  initial begin
    int hs, dn, unstable, stray;
    logic prev_v, prev_hs;
    logic [4:0] pp;
    logic [63:0] pr;

    for (int i = 0; i < 32; i++) set_entry(i, 4'd0, 32'd0, 32'd0);
    reset = 1'b1; start = 1'b1; first_ptr = 5'd3; last_ptr = 5'd4; rif.res_ready = 1'b1;

    // Reset held with start and res_ready high
    repeat (3) step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(rif.res_valid), 64'd0);
    chk("rst_rdptr", 64'(read_pointer), 64'd0);
    chk("rst_result", rif.result, 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    start = 1'b0; reset = 1'b0;
    step();
    chk("idle_busy", 64'(busy), 64'd0);

    // Single ADD, first == last
    set_entry(0, 4'd3, -32'sd7, 32'sd12);
    start_seq(5'd0, 5'd0);
    chk("t2_busy", 64'(busy), 64'd1);
    chk("t2_v_n1", 64'(rif.res_valid), 64'd0);
    step();
    chk("t2_v_n2", 64'(rif.res_valid), 64'd0);
    step();
    chk("t2_v_n3", 64'(rif.res_valid), 64'd1);
    chk("t2_result", rif.result, 64'd5);
    chk("t2_ptr", 64'(rif.res_ptr), 64'd0);
    chk("t2_opc", 64'(rif.res_opc), 64'd3);
    chk("t2_done_early", 64'(done), 64'd0);
    step();
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_v_after", 64'(rif.res_valid), 64'd0);
    step();
    chk("t2_done_off", 64'(done), 64'd0);
    chk("t2_idle", 64'(busy), 64'd0);

    // Every opcode with a=-15 b=4
    for (int i = 0; i < 8; i++) set_entry(i, 4'(i), -32'sd15, 32'sd4);
    start_seq(5'd0, 5'd7);
    for (int i = 0; i < 8; i++) begin
      wait_valid($sformatf("t3_lat%0d", i), (i >= 6) ? 34 : 2);
      chk($sformatf("t3_res%0d", i), rif.result, 64'(exp3[i]));
      chk($sformatf("t3_ptr%0d", i), 64'(rif.res_ptr), 64'(i));
      chk($sformatf("t3_opc%0d", i), 64'(rif.res_opc), 64'(i));
      step();
    end
    chk("t3_done", 64'(done), 64'd1);
    step();
    chk("t3_idle", 64'(busy), 64'd0);

    // Divide by zero, div_zero clearing, overflow corner, full-width MULT, MOD sign
    set_entry(10, 4'd6, 32'sd9, 32'sd0);
    set_entry(11, 4'd7, 32'sd9, 32'sd0);
    set_entry(12, 4'd3, 32'sd1, 32'sd2);
    set_entry(13, 4'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    set_entry(14, 4'd5, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    set_entry(15, 4'd7, 32'sd7, -32'sd2);
    start_seq(5'd10, 5'd15);
    for (int i = 0; i < 6; i++) begin
      wait_valid($sformatf("t4_lat%0d", i), lat4[i]);
      chk($sformatf("t4_res%0d", i), rif.result, 64'(exp4[i]));
      chk($sformatf("t4_dz%0d", i), 64'(rif.div_zero), 64'(dz4[i]));
      step();
    end
    chk("t4_done", 64'(done), 64'd1);
    step();

    // Wrapping range 30..1 with res_ready toggling every cycle
    set_entry(30, 4'd3, 32'sd100, -32'sd1);
    set_entry(31, 4'd4, 32'sd5, 32'sd8);
    set_entry(0, 4'd5, -32'sd3, 32'sd7);
    set_entry(1, 4'd2, 32'sd0, -32'sd42);
    rif.res_ready = 1'b0;
    start_seq(5'd30, 5'd1);
    hs = 0; dn = 0; unstable = 0; prev_v = 1'b0; prev_hs = 1'b0; pp = 5'd0; pr = 64'd0;
    for (int c = 0; c < 40; c++) begin
      if (rif.res_valid && prev_v && !prev_hs && (rif.res_ptr !== pp || rif.result !== pr)) unstable++;
      if (done === 1'b1) dn++;
      prev_hs = rif.res_valid && rif.res_ready;
      if (prev_hs) begin
        if (hs < 4) begin
          chk($sformatf("t5_ptr%0d", hs), 64'(rif.res_ptr), 64'(ep5[hs]));
          chk($sformatf("t5_res%0d", hs), rif.result, 64'(er5[hs]));
        end
        hs++;
      end
      prev_v = rif.res_valid; pp = rif.res_ptr; pr = rif.result;
      step();
      rif.res_ready = ~rif.res_ready;
    end
    chk("t5_handshakes", 64'(hs), 64'd4);
    chk("t5_dones", 64'(dn), 64'd1);
    chk("t5_unstable", 64'(unstable), 64'd0);
    chk("t5_idle", 64'(busy), 64'd0);

    // Reset during DIVIDE aborts; then a fresh run completes
    rif.res_ready = 1'b1;
    set_entry(5, 4'd6, 32'sd100, 32'sd7);
    start_seq(5'd5, 5'd5);
    repeat (5) step();
    chk("t6_busy_div", 64'(busy), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_busy_rst", 64'(busy), 64'd0);
    chk("t6_valid_rst", 64'(rif.res_valid), 64'd0);
    stray = 0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1 || rif.res_valid === 1'b1 || busy === 1'b1) stray++;
      step();
    end
    chk("t6_no_activity", 64'(stray), 64'd0);
    start_seq(5'd5, 5'd5);
    wait_valid("t6_lat", 34);
    chk("t6_res", rif.result, 64'd14);
    step();
    chk("t6_done", 64'(done), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
